// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and width helpers for the pipeline hazard controller.
// The stage record is sized for the largest legal pipeline depth.
package pipe_hazard_ctrl_pkg;

  localparam int RDY_MAXW = 3;
  localparam int BYP_RF   = 0;

  typedef struct packed {
    logic                val;
    logic                wen;
    logic [4:0]          rd;
    logic [RDY_MAXW-1:0] rdy;
  } stage_rec_t;

  localparam int REC_W = $bits(stage_rec_t);

  // Width of a stage index (rdy field on the D port)
  function automatic int sw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a bypass select: 0 = RF, k = stage k-1
  function automatic int bw_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stage.sv
// One tracked pipeline stage record: clear loads a bubble and wins over load.
module hazard_stage_reg
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [REC_W-1:0] d,
  output logic [REC_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/bypass controller for an in-order pipeline: tracks writers after D,
// selects bypass sources, stalls on late results and multi-cycle multiplies.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int MUL_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        val_D,
  input  logic                        rs1_en_D,
  input  logic                        rs2_en_D,
  input  logic [4:0]                  rs1_D,
  input  logic [4:0]                  rs2_D,
  input  logic [4:0]                  rd_D,
  input  logic                        wen_D,
  input  logic [sw_f(NSTAGES)-1:0]    rdy_D,
  input  logic                        mul_D,
  input  logic                        jump_D,
  input  logic                        br_taken_X,
  output logic                        reg_en_F,
  output logic                        reg_en_D,
  output logic                        squash_F,
  output logic                        squash_D,
  output logic [bw_f(NSTAGES)-1:0]    op1_byp_sel_D,
  output logic [bw_f(NSTAGES)-1:0]    op2_byp_sel_D,
  output logic                        val_X,
  output logic                        rf_wen_W,
  output logic [4:0]                  rf_waddr_W
);

  localparam int BW = bw_f(NSTAGES);

  stage_rec_t         stg_q [NSTAGES];
  stage_rec_t         stg_d [NSTAGES];
  logic [NSTAGES-1:0] stg_en;
  logic [NSTAGES-1:0] stg_clr;
  logic [NSTAGES-1:0] m1;
  logic [NSTAGES-1:0] m2;
  logic [3:0]         busy_cnt_reg;
  logic               busy;
  logic               need1;
  logic               need2;
  logic               stall1;
  logic               stall2;
  logic               stall_hz;
  logic               stall_d;
  logic               squash;
  logic               mul_enter;
  logic [BW-1:0]      sel1;
  logic [BW-1:0]      sel2;

  assign need1 = val_D && rs1_en_D && (rs1_D != 5'd0);
  assign need2 = val_D && rs2_en_D && (rs2_D != 5'd0);

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_match
    assign m1[gi] = need1 && stg_q[gi].val && stg_q[gi].wen && (stg_q[gi].rd == rs1_D);
    assign m2[gi] = need2 && stg_q[gi].val && stg_q[gi].wen && (stg_q[gi].rd == rs2_D);
  end

  // Scan oldest to youngest so the youngest matching writer has the last word.
  always_comb begin
    sel1   = BW'(BYP_RF);
    sel2   = BW'(BYP_RF);
    stall1 = 1'b0;
    stall2 = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (m1[k]) begin
        stall1 = int'(stg_q[k].rdy) > k;
        sel1   = stall1 ? BW'(BYP_RF) : BW'(k + 1);
      end
      if (m2[k]) begin
        stall2 = int'(stg_q[k].rdy) > k;
        sel2   = stall2 ? BW'(BYP_RF) : BW'(k + 1);
      end
    end
  end

  assign busy      = (busy_cnt_reg != 4'd0);
  assign stall_hz  = stall1 | stall2;
  assign stall_d   = stall_hz | busy;
  assign squash    = br_taken_X & stg_q[0].val;
  assign mul_enter = ~busy & ~stall_hz & ~squash & val_D & mul_D;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_reg <= 4'd0;
    end else if (mul_enter) begin
      busy_cnt_reg <= 4'(MUL_LAT - 1);
    end else if (busy) begin
      busy_cnt_reg <= busy_cnt_reg - 4'd1;
    end
  end

  // X holds during a multiply while a bubble is pushed into the stage behind it.
  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_x
      assign stg_d[gi]   = '{val: val_D, wen: wen_D, rd: rd_D, rdy: RDY_MAXW'(rdy_D)};
      assign stg_en[gi]  = ~busy;
      assign stg_clr[gi] = ~busy & (stall_hz | squash);
    end else if (gi == 1) begin : g_m
      assign stg_d[gi]   = stg_q[gi-1];
      assign stg_en[gi]  = 1'b1;
      assign stg_clr[gi] = busy;
    end else begin : g_tail
      assign stg_d[gi]   = stg_q[gi-1];
      assign stg_en[gi]  = 1'b1;
      assign stg_clr[gi] = 1'b0;
    end

    hazard_stage_reg u_reg (
      .clk (clk),
      .rst (rst),
      .en  (stg_en[gi]),
      .clr (stg_clr[gi]),
      .d   (stg_d[gi]),
      .q   (stg_q[gi])
    );
  end

  assign reg_en_F      = ~stall_d | squash;
  assign reg_en_D      = ~stall_d | squash;
  assign squash_D      = squash;
  assign squash_F      = squash | (jump_D & val_D & ~stall_d & ~rst);
  assign op1_byp_sel_D = sel1;
  assign op2_byp_sel_D = sel2;
  assign val_X         = stg_q[0].val;
  assign rf_wen_W      = stg_q[NSTAGES-1].val & stg_q[NSTAGES-1].wen;
  assign rf_waddr_W    = rf_wen_W ? stg_q[NSTAGES-1].rd : 5'd0;

endmodule
